drawbridge: RTL and testbench



---
 rtl/drawbridge.sv | 167 ++++++++++++++++
 tb/tb_drawbridge.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/drawbridge.sv
// drawbridge: Moore controller for a road drawbridge over a shipping channel.
// Tracks cars on the deck. Closes the barrier and sounds the alert when a boat
// approaches. Raises the span only once the deck has been seen empty.
module drawbridge #(
    parameter int CNT_W = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_carIn,
    input  logic       i_carOut,
    input  logic       i_boatClose,
    input  logic       i_boatHere,
    output logic       has_car_c,
    output logic       o_carBarrier,
    output logic       o_alert,
    output logic       o_bridge_s,
    output logic [2:0] machine_state
);

    typedef enum logic [2:0] {
        IDLE        = 3'b000,
        CARS        = 3'b001,
        BOAT_C_CARS = 3'b010,
        BOAT_C      = 3'b011,
        BOAT_PASS   = 3'b100,
        LOWER       = 3'b101
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             boat;
    logic             entry_ok;
    logic             inc;
    logic             dec;

    // Saturating up/down step. Simultaneous entry and exit cancel out. An
    // increment at full scale holds the count. A decrement at zero is dropped
    // by the caller, because dec is already qualified with count != 0.
    function automatic logic [CNT_W-1:0] sat_step(
        input logic [CNT_W-1:0] c,
        input logic             up,
        input logic             down
    );
        logic [CNT_W-1:0] max_c;
        logic [CNT_W-1:0] r;
        max_c = {CNT_W{1'b1}};
        r     = c;
        if (up && !down) begin
            if (c != max_c) begin
                r = c + 1'b1;
            end
        end else if (down && !up) begin
            if (c != '0) begin
                r = c - 1'b1;
            end
        end
        return r;
    endfunction

    // Cars may only be admitted while the road is open and no boat is near.
    always_comb begin
        boat     = i_boatClose | i_boatHere;
        entry_ok = ((state == IDLE) || (state == CARS)) && !i_boatClose && !i_boatHere;
        inc      = i_carIn & entry_ok;
        dec      = i_carOut & (count != '0);
        count_next = sat_step(count, inc, dec);
    end

    // Next-state logic. Decisions about an empty deck use count_next, so the
    // cycle in which the last car leaves already counts as empty.
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE: begin
                if (boat) begin
                    state_next = BOAT_C;
                end else if (count_next != '0) begin
                    state_next = CARS;
                end else begin
                    state_next = IDLE;
                end
            end
            CARS: begin
                if (boat) begin
                    state_next = BOAT_C_CARS;
                end else if (count_next == '0) begin
                    state_next = IDLE;
                end else begin
                    state_next = CARS;
                end
            end
            BOAT_C_CARS: begin
                // Wait for the deck to clear; new arrivals are blocked by entry_ok.
                if (count_next == '0) begin
                    state_next = boat ? BOAT_C : IDLE;
                end else begin
                    state_next = BOAT_C_CARS;
                end
            end
            BOAT_C: begin
                if (i_boatHere) begin
                    state_next = BOAT_PASS;
                end else if (!boat) begin
                    state_next = LOWER;
                end else begin
                    state_next = BOAT_C;
                end
            end
            BOAT_PASS: begin
                state_next = i_boatHere ? BOAT_PASS : LOWER;
            end
            LOWER: begin
                // Single-cycle lowering; a following boat re-raises straight away.
                state_next = boat ? BOAT_C : IDLE;
            end
            default: begin
                // Unused codes 110/111 recover to IDLE.
                state_next = IDLE;
            end
        endcase
    end

    // State and car-count registers; reset drops the count and opens the road.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= IDLE;
            count     <= '0;
            has_car_c <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            has_car_c <= (count_next != '0);
        end
    end

    // Moore output decode from the registered state only.
    always_comb begin
        o_carBarrier = 1'b0;
        o_alert      = 1'b0;
        o_bridge_s   = 1'b0;
        case (state)
            BOAT_C_CARS: begin
                o_carBarrier = 1'b1;
                o_alert      = 1'b1;
            end
            BOAT_C, BOAT_PASS: begin
                o_carBarrier = 1'b1;
                o_alert      = 1'b1;
                o_bridge_s   = 1'b1;
            end
            LOWER: begin
                o_carBarrier = 1'b1;
                o_alert      = 1'b1;
            end
            default: begin
                o_carBarrier = 1'b0;
                o_alert      = 1'b0;
                o_bridge_s   = 1'b0;
            end
        endcase
    end

    assign machine_state = state;

endmodule

// File: tb/tb_drawbridge.sv
// tb_drawbridge: directed test of the drawbridge controller.
module tb_drawbridge;

    logic       i_clk;
    logic       i_reset;
    logic       i_carIn;
    logic       i_carOut;
    logic       i_boatClose;
    logic       i_boatHere;
    logic       has_car_c;
    logic       o_carBarrier;
    logic       o_alert;
    logic       o_bridge_s;
    logic [2:0] machine_state;

    int n_chk;
    int n_fail;

    drawbridge #(.CNT_W(4)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_carIn      (i_carIn),
        .i_carOut     (i_carOut),
        .i_boatClose  (i_boatClose),
        .i_boatHere   (i_boatHere),
        .has_car_c    (has_car_c),
        .o_carBarrier (o_carBarrier),
        .o_alert      (o_alert),
        .o_bridge_s   (o_bridge_s),
        .machine_state(machine_state)
    );

    // 40 ns period, first rising edge at 40 ns
    initial begin
        i_clk = 1'b1;
        forever #20 i_clk = ~i_clk;
    end

    task automatic chk_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 5 ns past it
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk);
            #5;
        end
    endtask

    task automatic chk_outs(input string tag, input logic [2:0] st, input logic car,
                            input logic bar, input logic alr, input logic brg);
        chk_eq({tag, ".state"},   {5'd0, machine_state}, {5'd0, st});
        chk_eq({tag, ".has_car"}, {7'd0, has_car_c},     {7'd0, car});
        chk_eq({tag, ".barrier"}, {7'd0, o_carBarrier},  {7'd0, bar});
        chk_eq({tag, ".alert"},   {7'd0, o_alert},       {7'd0, alr});
        chk_eq({tag, ".bridge"},  {7'd0, o_bridge_s},    {7'd0, brg});
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        i_reset     = 1'b1;
        i_carIn     = 1'b0;
        i_carOut    = 1'b0;
        i_boatClose = 1'b0;
        i_boatHere  = 1'b0;

        // Reset
        #20;
        i_reset = 1'b0;
        #5;
        chk_outs("reset", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Two cars in, two cars out
        i_carIn = 1'b1;
        tick(2);
        chk_outs("cars_in2", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        i_carIn  = 1'b0;
        i_carOut = 1'b1;
        tick(1);
        chk_outs("cars_out1", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        chk_outs("cars_out2", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        i_carOut = 1'b0;

        // Boat arrives with two cars on the deck
        i_carIn = 1'b1;
        tick(2);
        i_carIn     = 1'b0;
        i_boatClose = 1'b1;
        tick(1);
        chk_outs("boat_cars", 3'b010, 1'b1, 1'b1, 1'b1, 1'b0);
        i_carIn = 1'b1;
        tick(1);
        chk_outs("boat_cars_in_ign", 3'b010, 1'b1, 1'b1, 1'b1, 1'b0);
        i_carIn  = 1'b0;
        i_carOut = 1'b1;
        tick(1);
        chk_outs("boat_cars_out1", 3'b010, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(1);
        chk_outs("boat_c", 3'b011, 1'b0, 1'b1, 1'b1, 1'b1);
        i_carOut = 1'b0;

        // Boat passes, bridge lowers, road reopens
        i_boatHere = 1'b1;
        tick(1);
        chk_outs("boat_pass", 3'b100, 1'b0, 1'b1, 1'b1, 1'b1);
        i_boatHere  = 1'b0;
        i_boatClose = 1'b0;
        tick(1);
        chk_outs("lower", 3'b101, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(1);
        chk_outs("lower_idle", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Boat and car on the same edge in IDLE: car is refused
        i_boatClose = 1'b1;
        i_carIn     = 1'b1;
        tick(1);
        chk_outs("idle_boat_car", 3'b011, 1'b0, 1'b1, 1'b1, 1'b1);
        i_boatClose = 1'b0;
        i_carIn     = 1'b0;
        tick(2);
        chk_outs("back_idle", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Simultaneous in/out leaves the count unchanged
        i_carIn = 1'b1;
        tick(1);
        i_carOut = 1'b1;
        tick(1);
        chk_outs("inout_same", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        i_carIn = 1'b0;
        tick(1);
        chk_outs("inout_empty", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        // Exit with an empty deck is ignored (no wrap to 15)
        tick(1);
        i_carOut = 1'b0;
        i_carIn  = 1'b1;
        tick(1);
        i_carIn  = 1'b0;
        i_carOut = 1'b1;
        tick(1);
        chk_outs("dec_at_zero", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        i_carOut = 1'b0;

        // Saturation at 15: 16 entries then 14 exits leave one car
        i_carIn = 1'b1;
        tick(16);
        chk_outs("sat_full", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        i_carIn  = 1'b0;
        i_carOut = 1'b1;
        tick(14);
        chk_outs("sat_out14", 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        chk_outs("sat_out15", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        i_carOut = 1'b0;

        // Boat leaves while cars still on deck: return to IDLE once empty
        i_carIn = 1'b1;
        tick(1);
        i_carIn     = 1'b0;
        i_boatClose = 1'b1;
        tick(1);
        i_boatClose = 1'b0;
        i_carOut    = 1'b1;
        tick(1);
        chk_outs("boat_gone_empty", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        i_carOut = 1'b0;

        // Asynchronous reset during BOAT_PASS
        i_boatHere = 1'b1;
        tick(2);
        chk_outs("pre_reset_pass", 3'b100, 1'b0, 1'b1, 1'b1, 1'b1);
        #3;
        i_reset = 1'b1;
        #1;
        chk_outs("async_reset", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        i_boatHere = 1'b0;
        #10;
        i_reset = 1'b0;
        tick(1);
        chk_outs("post_reset", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
